// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants.
// Used by both uart_receiver and uart_transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Baud ticks per bit period and the tick index that lands mid start bit.
    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 7;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RX line.
// Resets to 1 so that reset never looks like a start edge.
module uart_rx_sync (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic sync_q;

    // Two-stage shift of the raw line; fixed 2-clock latency.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 16x oversampled UART receiver, LSB first, DATA_BITS data bits, configurable stop length.
// Optional feature: define UART_RX_FERR_EN to add the o_frame_err output (stop bit sampled low).
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DATA_BITS      = 32,
    parameter int STP_BITS_TICKS = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_bd_tick,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_rx_done
`ifdef UART_RX_FERR_EN
    ,
    output logic                 o_frame_err
`endif
);

    localparam int TICK_CLOG = $clog2(STP_BITS_TICKS);
    localparam int TICK_W    = (TICK_CLOG > 4) ? TICK_CLOG : 4;
    localparam int BIT_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    logic                 rx_s;
    uart_state_e          state_q, state_d;
    logic [TICK_W-1:0]    tick_q,  tick_d;
    logic [BIT_W-1:0]     bit_q,   bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_q,  data_d;
    logic                 done_q,  done_d;
`ifdef UART_RX_FERR_EN
    logic                 ferr_q,  ferr_d;
`endif

    uart_rx_sync u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_rx),
        .o_q     (rx_s)
    );

    // Next-state logic: frame sequencing on baud ticks, sampling mid-bit.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        done_d  = 1'b0;
`ifdef UART_RX_FERR_EN
        ferr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // Start edge is taken without waiting for a tick.
                if (!rx_s) begin
                    state_d = START;
                    tick_d  = '0;
                end
            end
            START: begin
                if (i_bd_tick) begin
                    if (tick_q == TICK_W'(MID_TICK)) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            tick_d  = '0;
                            bit_d   = '0;
                        end else begin
                            // Line went back high before mid start bit: a glitch.
                            state_d = IDLE;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
            DATA: begin
                if (i_bd_tick) begin
                    if (tick_q == TICK_W'(OVERSAMPLE - 1)) begin
                        // LSB arrives first, so new bits enter at the top and shift down.
                        shreg_d = (shreg_q >> 1) | (DATA_BITS'(rx_s) << (DATA_BITS - 1));
                        tick_d  = '0;
                        if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
            STOP: begin
                if (i_bd_tick) begin
                    if (tick_q == TICK_W'(STP_BITS_TICKS - 1)) begin
                        data_d  = shreg_q;
                        done_d  = 1'b1;
`ifdef UART_RX_FERR_EN
                        ferr_d  = !rx_s;
`endif
                        state_d = IDLE;
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
`ifdef UART_RX_FERR_EN
            ferr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            done_q  <= done_d;
`ifdef UART_RX_FERR_EN
            ferr_q  <= ferr_d;
`endif
        end
    end

    assign o_data    = data_q;
    assign o_rx_done = done_q;
`ifdef UART_RX_FERR_EN
    assign o_frame_err = ferr_q;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: an 8-bit and a 32-bit instance, each fed by its own serial line.
// Frames are built bit by bit; received words are collected by a monitor and compared
// against the list of words sent.
module tb_uart_receiver;

    localparam int BIT_CLKS = 64;   // 16 ticks per bit, one tick every 4 clocks

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick  = 1'b0;
    logic        rx8   = 1'b1;
    logic        rx32  = 1'b1;
    logic [7:0]  data8;
    logic        done8;
    logic [31:0] data32;
    logic        done32;
`ifdef UART_RX_FERR_EN
    logic        ferr8;
    logic        ferr32;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0]  obs8[$];
    logic        obsf8[$];
    logic [31:0] obs32[$];
    logic [7:0]  last8;
    logic [31:0] last32;

    uart_receiver #(.DATA_BITS(8), .STP_BITS_TICKS(16)) dut8 (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_bd_tick   (tick),
        .i_rx        (rx8),
        .o_data      (data8),
`ifdef UART_RX_FERR_EN
        .o_frame_err (ferr8),
`endif
        .o_rx_done   (done8)
    );

    uart_receiver #(.DATA_BITS(32), .STP_BITS_TICKS(16)) dut32 (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_bd_tick   (tick),
        .i_rx        (rx32),
        .o_data      (data32),
`ifdef UART_RX_FERR_EN
        .o_frame_err (ferr32),
`endif
        .o_rx_done   (done32)
    );

    always #5 clk = ~clk;

    // Baud tick: one-clock pulse every 4 clocks.
    initial begin
        forever begin
            repeat (3) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    // Monitor: every cycle with a strobe records one received word.
    initial begin
        forever begin
            @(negedge clk);
            if (done8 === 1'b1) begin
                obs8.push_back(data8);
`ifdef UART_RX_FERR_EN
                obsf8.push_back(ferr8);
`else
                obsf8.push_back(1'b0);
`endif
            end
            if (done32 === 1'b1) obs32.push_back(data32);
        end
    end

    task automatic drive(input int which, input logic v, input int clks);
        if (which == 0) rx8 = v; else rx32 = v;
        repeat (clks) @(negedge clk);
    endtask

    task automatic send_frame(input int which, input logic [31:0] w, input int nbits,
                              input logic stop_v, input int stop_clks);
        drive(which, 1'b0, BIT_CLKS);
        for (int i = 0; i < nbits; i++) drive(which, w[i], BIT_CLKS);
        drive(which, stop_v, stop_clks);
        if (which == 0) rx8 = 1'b1; else rx32 = 1'b1;
    endtask

    task automatic clear_obs();
        obs8.delete();
        obsf8.delete();
        obs32.delete();
    endtask

    task automatic test_reset();
        repeat (5) @(negedge clk);
        total++; if (data8 !== 8'h00) begin bad++; $display("FAIL reset_data8 got=%h exp=00", data8); end
        total++; if (done8 !== 1'b0) begin bad++; $display("FAIL reset_done8 got=%b exp=0", done8); end
        total++; if (data32 !== 32'h0) begin bad++; $display("FAIL reset_data32 got=%h exp=0", data32); end
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        total++; if (obs8.size() != 0) begin bad++; $display("FAIL reset_no_strobe got=%0d exp=0", obs8.size()); end
        last8  = 8'h00;
        last32 = 32'h0;
    endtask

    task automatic test_single_a5();
        clear_obs();
        send_frame(0, 32'hA5, 8, 1'b1, BIT_CLKS);
        repeat (32) @(negedge clk);
        total++; if (obs8.size() != 1) begin bad++; $display("FAIL a5_count got=%0d exp=1", obs8.size()); end
        else begin
            total++; if (obs8[0] !== 8'hA5) begin bad++; $display("FAIL a5_data got=%h exp=a5", obs8[0]); end
            total++; if (obsf8[0] !== 1'b0) begin bad++; $display("FAIL a5_ferr got=%b exp=0", obsf8[0]); end
        end
        total++; if (data8 !== 8'hA5) begin bad++; $display("FAIL a5_hold got=%h exp=a5", data8); end
        last8 = 8'hA5;
    endtask

    task automatic test_wide_word();
        clear_obs();
        send_frame(1, 32'hDEADBEEF, 32, 1'b1, BIT_CLKS);
        repeat (32) @(negedge clk);
        total++; if (obs32.size() != 1) begin bad++; $display("FAIL wide_count got=%0d exp=1", obs32.size()); end
        else begin
            total++; if (obs32[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL wide_data got=%h exp=deadbeef", obs32[0]); end
        end
        last32 = 32'hDEADBEEF;
    endtask

    task automatic test_glitch();
        clear_obs();
        drive(0, 1'b0, 16);          // 4 ticks low, well short of mid start bit
        drive(0, 1'b1, 12 * BIT_CLKS);
        total++; if (obs8.size() != 0) begin bad++; $display("FAIL glitch_count got=%0d exp=0", obs8.size()); end
        total++; if (data8 !== last8) begin bad++; $display("FAIL glitch_data got=%h exp=%h", data8, last8); end
    endtask

    task automatic test_stop_low();
        clear_obs();
        // Low stop bit released early enough that the re-armed start is seen as a glitch.
        send_frame(0, 32'h3C, 8, 1'b0, 48);
        repeat (3 * BIT_CLKS) @(negedge clk);
        total++; if (obs8.size() != 1) begin bad++; $display("FAIL ferr_count got=%0d exp=1", obs8.size()); end
        else begin
            total++; if (obs8[0] !== 8'h3C) begin bad++; $display("FAIL ferr_data got=%h exp=3c", obs8[0]); end
`ifdef UART_RX_FERR_EN
            total++; if (obsf8[0] !== 1'b1) begin bad++; $display("FAIL ferr_flag got=%b exp=1", obsf8[0]); end
`endif
        end
        last8 = 8'h3C;
    endtask

    task automatic test_back_to_back();
        clear_obs();
        send_frame(0, 32'h00, 8, 1'b1, BIT_CLKS);
        send_frame(0, 32'hFF, 8, 1'b1, BIT_CLKS);
        repeat (32) @(negedge clk);
        total++; if (obs8.size() != 2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", obs8.size()); end
        else begin
            total++; if (obs8[0] !== 8'h00) begin bad++; $display("FAIL b2b_first got=%h exp=00", obs8[0]); end
            total++; if (obs8[1] !== 8'hFF) begin bad++; $display("FAIL b2b_second got=%h exp=ff", obs8[1]); end
        end
        last8 = 8'hFF;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] w;
        w = 8'h5A;
        clear_obs();
        drive(0, 1'b0, BIT_CLKS);
        for (int i = 0; i < 3; i++) drive(0, w[i], BIT_CLKS);
        drive(0, w[3], BIT_CLKS / 2);
        rst_n = 1'b0;
        #1;
        total++; if (data8 !== 8'h00) begin bad++; $display("FAIL rstmid_data got=%h exp=00", data8); end
        total++; if (done8 !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b exp=0", done8); end
        rx8 = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        total++; if (obs8.size() != 0) begin bad++; $display("FAIL rstmid_nostrobe got=%0d exp=0", obs8.size()); end
        send_frame(0, 32'h5A, 8, 1'b1, BIT_CLKS);
        repeat (32) @(negedge clk);
        total++; if (obs8.size() != 1) begin bad++; $display("FAIL rstmid_count got=%0d exp=1", obs8.size()); end
        else begin
            total++; if (obs8[0] !== 8'h5A) begin bad++; $display("FAIL rstmid_frame got=%h exp=5a", obs8[0]); end
        end
        last8  = 8'h5A;
        last32 = 32'h0;
    endtask

    task automatic test_random();
        logic [7:0]  exp8[$];
        logic [31:0] exp32[$];
        logic [7:0]  b;
        logic [31:0] w;
        clear_obs();
        for (int n = 0; n < 10; n++) begin
            b = 8'($urandom);
            exp8.push_back(b);
            send_frame(0, {24'h0, b}, 8, 1'b1, BIT_CLKS);
            drive(0, 1'b1, $urandom_range(0, 2 * BIT_CLKS));
        end
        for (int n = 0; n < 3; n++) begin
            w = $urandom;
            exp32.push_back(w);
            send_frame(1, w, 32, 1'b1, BIT_CLKS);
        end
        repeat (32) @(negedge clk);
        total++; if (obs8.size() != exp8.size()) begin bad++; $display("FAIL rand8_count got=%0d exp=%0d", obs8.size(), exp8.size()); end
        else begin
            for (int i = 0; i < exp8.size(); i++) begin
                total++; if (obs8[i] !== exp8[i]) begin bad++; $display("FAIL rand8_data[%0d] got=%h exp=%h", i, obs8[i], exp8[i]); end
                total++; if (obsf8[i] !== 1'b0) begin bad++; $display("FAIL rand8_ferr[%0d] got=%b exp=0", i, obsf8[i]); end
            end
        end
        total++; if (obs32.size() != exp32.size()) begin bad++; $display("FAIL rand32_count got=%0d exp=%0d", obs32.size(), exp32.size()); end
        else begin
            for (int i = 0; i < exp32.size(); i++) begin
                total++; if (obs32[i] !== exp32[i]) begin bad++; $display("FAIL rand32_data[%0d] got=%h exp=%h", i, obs32[i], exp32[i]); end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_a5();
        test_wide_word();
        test_glitch();
        test_stop_low();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
